// File: rtl/maze_pkg.sv
// Shared definitions for the maze pixel renderer.
// Contents: grid geometry, colour constants, the player-marker inset, a
// cell-coordinate struct, the per-pixel pipeline record, and helpers that map
// a (row, col) pair to a wall-map index and range-check a cell.
package maze_pkg;

  localparam int COLS       = 20;
  localparam int ROWS       = 15;
  localparam int CELLS      = COLS * ROWS;
  localparam int CELL_SHIFT = 5;
  localparam int ADDR_W     = 9;

  localparam logic [11:0] WALL   = 12'h000;
  localparam logic [11:0] PATH   = 12'hFFF;
  localparam logic [11:0] PLAYER = 12'hF00;
  localparam logic [11:0] GOAL   = 12'h0F0;
  localparam logic [11:0] BLANK  = 12'h000;

  // The player is drawn as a square inset 4 px from each edge of its cell.
  localparam logic [4:0] MARK_LO = 5'd4;
  localparam logic [4:0] MARK_HI = 5'd27;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } cell_t;

  localparam cell_t PLAYER_RST = '{x: 5'd0,  y: 4'd0};
  localparam cell_t GOAL_RST   = '{x: 5'd19, y: 4'd14};

  // One pixel as it travels through the pipeline.
  typedef struct packed {
    logic [4:0] col;
    logic [3:0] row;
    logic [4:0] ox;
    logic [4:0] oy;
    logic       bright;
    logic       hsync;
    logic       vsync;
  } pix_t;

  function automatic logic [ADDR_W-1:0] cell_index(input logic [3:0] row,
                                                  input logic [4:0] col);
    return ADDR_W'(int'(row) * COLS + int'(col));
  endfunction

  function automatic logic cell_in_range(input cell_t c);
    return (int'(c.x) < COLS) && (int'(c.y) < ROWS);
  endfunction

endpackage

// File: rtl/maze_pixel_renderer_if.sv
// Bundle of the renderer's video timing inputs, map/position update strobes
// and pixel outputs.
// master: the side that drives timing and updates (timing generator / game
//         logic) and consumes rgb, delayed syncs and at_goal.
// slave : the renderer itself.
interface maze_pixel_renderer_if;

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        bright;
  logic        hsync;
  logic        vsync;

  logic        wall_we;
  logic [8:0]  wall_addr;
  logic        wall_data;

  logic        pos_we;
  logic [4:0]  player_x;
  logic [3:0]  player_y;
  logic [4:0]  goal_x;
  logic [3:0]  goal_y;

  logic [11:0] rgb;
  logic        hsync_o;
  logic        vsync_o;
  logic        bright_o;
  logic        at_goal;

  modport master (
    output hc, vc, bright, hsync, vsync,
    output wall_we, wall_addr, wall_data,
    output pos_we, player_x, player_y, goal_x, goal_y,
    input  rgb, hsync_o, vsync_o, bright_o, at_goal
  );

  modport slave (
    input  hc, vc, bright, hsync, vsync,
    input  wall_we, wall_addr, wall_data,
    input  pos_we, player_x, player_y, goal_x, goal_y,
    output rgb, hsync_o, vsync_o, bright_o, at_goal
  );

endinterface

// File: rtl/maze_wall_ram.sv
// 300 x 1 wall map: one bit per cell, 1 = wall.
// Ports: clk, reset (sync, active-high), we/wr_addr/wr_data (synchronous
// write, addresses >= 300 ignored), rd_addr/rd_data (registered read, one
// cycle latency; addresses >= 300 read as 0).
module maze_wall_ram
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic [CELLS-1:0] mem;

  // NOTE: the map must read all-clear right after reset, so it is a flop
  // vector cleared in the reset branch rather than an unresettable RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem     <= '0;
      rd_data <= 1'b0;
    end else begin
      if (we && int'(wr_addr) < CELLS) mem[wr_addr] <= wr_data;
      rd_data <= (int'(rd_addr) < CELLS) ? mem[rd_addr] : 1'b0;
    end
  end

endmodule

// File: rtl/maze_pixel_renderer.sv
// Maze pixel renderer: turns VGA hc/vc into a colour from the wall map, the
// player cell and the goal cell, through a 3-stage pipeline.
// Ports: clk (pixel clock), reset (sync, active-high), bus (slave modport:
// hc/vc/bright/hsync/vsync in, wall and position update strobes in,
// rgb/hsync_o/vsync_o/bright_o/at_goal out, all aligned 3 cycles late).
module maze_pixel_renderer #(
  parameter int H_OFFSET   = 144,
  parameter int V_OFFSET   = 35,
  parameter int CELL_SHIFT = maze_pkg::CELL_SHIFT
) (
  input logic                  clk,
  input logic                  reset,
  maze_pixel_renderer_if.slave bus
);

  import maze_pkg::ADDR_W, maze_pkg::cell_t, maze_pkg::pix_t;
  import maze_pkg::cell_index, maze_pkg::cell_in_range;
  import maze_pkg::WALL, maze_pkg::PATH, maze_pkg::PLAYER, maze_pkg::GOAL;
  import maze_pkg::BLANK, maze_pkg::MARK_LO, maze_pkg::MARK_HI;
  import maze_pkg::PLAYER_RST, maze_pkg::GOAL_RST;

  localparam logic [9:0] OFS_MASK = 10'((1 << CELL_SHIFT) - 1);

  logic [9:0]  px, py;
  pix_t        s1, s2;
  logic        wall_bit;
  cell_t       new_player, new_goal;
  cell_t       sh_player, sh_goal, disp_player, disp_goal;
  logic        frame_start, pos_ok;
  logic        player_hit, goal_hit, in_mark;
  logic [11:0] rgb_next;

  // Stage 1: screen coordinates relative to the visible origin.
  assign px = bus.hc - 10'(H_OFFSET);
  assign py = bus.vc - 10'(V_OFFSET);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1.col    <= 5'(px >> CELL_SHIFT);
      s1.row    <= 4'(py >> CELL_SHIFT);
      s1.ox     <= 5'(px & OFS_MASK);
      s1.oy     <= 5'(py & OFS_MASK);
      s1.bright <= bus.bright;
      s1.hsync  <= bus.hsync;
      s1.vsync  <= bus.vsync;
      s2        <= s1;
    end
  end

  // Stage 2: the registered read lands alongside s2.
  maze_wall_ram u_wall_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wall_we),
    .wr_addr (ADDR_W'(bus.wall_addr)),
    .wr_data (bus.wall_data),
    .rd_addr (cell_index(s1.row, s1.col)),
    .rd_data (wall_bit)
  );

  // Double-buffered player/goal: updates land in the shadow copy and are
  // only shown from the next frame start, so a frame never tears.
  assign new_player  = '{x: bus.player_x, y: bus.player_y};
  assign new_goal    = '{x: bus.goal_x,   y: bus.goal_y};
  assign pos_ok      = cell_in_range(new_player) && cell_in_range(new_goal);
  assign frame_start = (bus.hc == 10'd0) && (bus.vc == 10'd0);

  // NOTE: non-blocking updates mean a shadow load and a frame-start copy in
  // the same cycle hand the displayed registers the old shadow value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_player   <= PLAYER_RST;
      sh_goal     <= GOAL_RST;
      disp_player <= PLAYER_RST;
      disp_goal   <= GOAL_RST;
      bus.at_goal <= 1'b0;
    end else begin
      if (bus.pos_we && pos_ok) begin
        sh_player <= new_player;
        sh_goal   <= new_goal;
      end
      if (frame_start) begin
        disp_player <= sh_player;
        disp_goal   <= sh_goal;
        bus.at_goal <= (sh_player == sh_goal);
      end else begin
        bus.at_goal <= (disp_player == disp_goal);
      end
    end
  end

  // Stage 3: colour priority.
  assign player_hit = (s2.col == disp_player.x) && (s2.row == disp_player.y);
  assign goal_hit   = (s2.col == disp_goal.x)   && (s2.row == disp_goal.y);
  assign in_mark    = (s2.ox >= MARK_LO) && (s2.ox <= MARK_HI) &&
                      (s2.oy >= MARK_LO) && (s2.oy <= MARK_HI);

  // NOTE: rgb_next gets a default first so no path can infer a latch.
  always_comb begin
    rgb_next = BLANK;
    if (!s2.bright)              rgb_next = BLANK;
    else if (player_hit && in_mark) rgb_next = PLAYER;
    else if (goal_hit)           rgb_next = GOAL;
    else if (wall_bit)           rgb_next = WALL;
    else                         rgb_next = PATH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rgb      <= BLANK;
      bus.hsync_o  <= 1'b0;
      bus.vsync_o  <= 1'b0;
      bus.bright_o <= 1'b0;
    end else begin
      bus.rgb      <= rgb_next;
      bus.hsync_o  <= s2.hsync;
      bus.vsync_o  <= s2.vsync;
      bus.bright_o <= s2.bright;
    end
  end

endmodule
